// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Framing errors and overruns are reported on sticky flags cleared by err_clear.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       RXD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  input  logic       err_clear
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] S_WAIT_HIGH = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;

  logic             rx_meta;
  logic             rxs;
  logic [1:0]       sync_primed;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;

  logic             stop_done;
  logic             push;
  logic             frame_set;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push_ok;
  logic             overrun_set;

  // Both synchroniser stages come out of reset high.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RXD;
      rxs     <= rx_meta;
    end
  end

  // The synchroniser shows its reset value for two cycles; WAIT_HIGH ignores
  // rxs until real line samples have reached it, so a low line stays unseen.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_primed <= 2'b00;
    end else begin
      sync_primed <= {sync_primed[0], 1'b1};
    end
  end

  assign stop_done = (state == S_STOP) && (cnt == BIT_LAST);
  assign push      = stop_done && rxs;
  assign frame_set = stop_done && !rxs;
  assign rx_busy   = (state != S_IDLE) && (state != S_WAIT_HIGH);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_WAIT_HIGH;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        S_WAIT_HIGH: begin
          if (sync_primed[1] && rxs) state <= S_IDLE;
        end
        S_IDLE: begin
          if (!rxs) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            idx <= '0;
            state <= rxs ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            shreg[idx] <= rxs;
            if (idx == 3'd7) state <= S_STOP;
            else idx <= idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          // Leaving at mid-stop lets the next start edge be caught immediately.
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= rxs ? S_IDLE : S_WAIT_HIGH;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_WAIT_HIGH;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Read port handshake: rx_valid means the head byte is on rx_data; the byte
  // is consumed on a cycle with rx_valid & rx_ready, and rx_valid never drops
  // without such a pop.
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rx_valid    = !empty;
  assign pop         = rx_valid && rx_ready;
  assign push_ok     = push && (!full || pop);
  assign overrun_set = push && full && !pop;
  assign rx_data     = rx_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // A new error in the same cycle as err_clear wins.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= (rx_frame_err && !err_clear) || frame_set;
      rx_overrun   <= (rx_overrun && !err_clear) || overrun_set;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames are bit-banged on RXD at 217 clk/bit
// and popped bytes are collected by a monitor for comparison against expected queues.
module tb_uart_rx_fifo;

  localparam int CPB = 217;

  logic       clk;
  logic       resetn;
  logic       RXD;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_busy;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       err_clear;

  int         n_pass;
  int         n_total;
  int         cyc;
  logic [7:0] got_q[$];
  int         got_cyc[$];
  logic [7:0] exp_q[$];

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .RXD          (RXD),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_busy      (rx_busy),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .err_clear    (err_clear)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #20 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pop monitor: inputs change on negedge, so sample a little later
  always @(negedge clk) begin
    #5;
    if (resetn && rx_valid && rx_ready) begin
      got_q.push_back(rx_data);
      got_cyc.push_back(cyc);
    end
  end

  // Driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int extra);
    RXD = 1'b0;
    wait_clks(CPB + extra);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      wait_clks(CPB);
    end
    RXD = stop_bit;
    wait_clks(CPB);
    RXD = 1'b1;
  endtask

  task automatic pulse_err_clear();
    err_clear = 1'b1;
    wait_clks(1);
    err_clear = 1'b0;
    wait_clks(1);
  endtask

  task automatic test_reset();
    resetn = 1'b0; RXD = 1'b1; rx_ready = 1'b0; err_clear = 1'b0;
    wait_clks(5);
    resetn = 1'b1;
    wait_clks(5);
    n_total++; if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rx_valid); else n_pass++;
    n_total++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", rx_data); else n_pass++;
    n_total++; if (rx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", rx_busy); else n_pass++;
    n_total++; if (rx_frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", rx_frame_err); else n_pass++;
    n_total++; if (rx_overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", rx_overrun); else n_pass++;
  endtask

  task automatic test_single_byte();
    int t0;
    got_q.delete(); got_cyc.delete();
    rx_ready = 1'b1;
    t0 = cyc;
    send_frame(8'h2A, 1'b1, 0);
    wait_clks(20);
    n_total++; if (got_q.size() !== 1) $display("FAIL single_count: got %0d want 1", got_q.size()); else n_pass++;
    if (got_q.size() >= 1) begin
      n_total++; if (got_q[0] !== 8'h2A) $display("FAIL single_data: got %h want 2a", got_q[0]); else n_pass++;
      // Stop-bit sample lands about 9.5 bit times (2061.5 clks) after the start edge
      n_total++;
      if (got_cyc[0] - t0 < 2055 || got_cyc[0] - t0 > 2070)
        $display("FAIL single_latency: got %0d clks want 2055..2070", got_cyc[0] - t0);
      else n_pass++;
    end
    n_total++; if (rx_frame_err !== 1'b0) $display("FAIL single_frame_err: got %b want 0", rx_frame_err); else n_pass++;
    n_total++; if (rx_overrun !== 1'b0) $display("FAIL single_overrun: got %b want 0", rx_overrun); else n_pass++;
  endtask

  task automatic test_back_to_back();
    got_q.delete(); got_cyc.delete();
    exp_q = '{8'h20, 8'h31, 8'h30};
    rx_ready = 1'b0;
    foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, 0);
    wait_clks(10);
    n_total++; if (got_q.size() !== 0) $display("FAIL b2b_early_pop: got %0d want 0", got_q.size()); else n_pass++;
    n_total++; if (rx_valid !== 1'b1) $display("FAIL b2b_valid: got %b want 1", rx_valid); else n_pass++;
    n_total++; if (rx_data !== 8'h20) $display("FAIL b2b_head: got %h want 20", rx_data); else n_pass++;
    rx_ready = 1'b1;
    wait_clks(6);
    n_total++; if (got_q.size() !== 3) $display("FAIL b2b_count: got %0d want 3", got_q.size()); else n_pass++;
    if (got_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        n_total++;
        if (got_q[i] !== exp_q[i]) $display("FAIL b2b_data%0d: got %h want %h", i, got_q[i], exp_q[i]);
        else n_pass++;
      end
      n_total++;
      if (got_cyc[1] != got_cyc[0] + 1 || got_cyc[2] != got_cyc[0] + 2)
        $display("FAIL b2b_consecutive: got cycles %0d %0d %0d want consecutive", got_cyc[0], got_cyc[1], got_cyc[2]);
      else n_pass++;
    end
    n_total++; if (rx_valid !== 1'b0) $display("FAIL b2b_drained: got %b want 0", rx_valid); else n_pass++;
    rx_ready = 1'b0;
  endtask

  task automatic test_overrun();
    logic [7:0] sent[5];
    got_q.delete(); got_cyc.delete();
    sent = '{8'h36, 8'h34, 8'h35, 8'h38, 8'h39};
    exp_q = '{8'h36, 8'h34, 8'h35, 8'h38};
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(sent[i], 1'b1, 0);
    wait_clks(10);
    n_total++; if (rx_overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", rx_overrun); else n_pass++;
    n_total++; if (rx_data !== 8'h36) $display("FAIL ovr_head: got %h want 36", rx_data); else n_pass++;
    n_total++; if (rx_frame_err !== 1'b0) $display("FAIL ovr_frame_err: got %b want 0", rx_frame_err); else n_pass++;
    pulse_err_clear();
    n_total++; if (rx_overrun !== 1'b0) $display("FAIL ovr_clear: got %b want 0", rx_overrun); else n_pass++;
    rx_ready = 1'b1;
    wait_clks(8);
    n_total++; if (got_q.size() !== 4) $display("FAIL ovr_count: got %0d want 4", got_q.size()); else n_pass++;
    if (got_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (got_q[i] !== exp_q[i]) $display("FAIL ovr_data%0d: got %h want %h", i, got_q[i], exp_q[i]);
        else n_pass++;
      end
    end
    n_total++; if (rx_valid !== 1'b0) $display("FAIL ovr_drained: got %b want 0", rx_valid); else n_pass++;
  endtask

  task automatic test_frame_error();
    got_q.delete(); got_cyc.delete();
    rx_ready = 1'b1;
    send_frame(8'h53, 1'b0, 0);
    wait_clks(30);
    n_total++; if (got_q.size() !== 0) $display("FAIL ferr_no_push: got %0d want 0", got_q.size()); else n_pass++;
    n_total++; if (rx_frame_err !== 1'b1) $display("FAIL ferr_flag: got %b want 1", rx_frame_err); else n_pass++;
    send_frame(8'h2F, 1'b1, 0);
    wait_clks(20);
    n_total++; if (got_q.size() !== 1) $display("FAIL ferr_recover_count: got %0d want 1", got_q.size()); else n_pass++;
    if (got_q.size() >= 1) begin
      n_total++; if (got_q[0] !== 8'h2F) $display("FAIL ferr_recover_data: got %h want 2f", got_q[0]); else n_pass++;
    end
    n_total++; if (rx_frame_err !== 1'b1) $display("FAIL ferr_sticky: got %b want 1", rx_frame_err); else n_pass++;
    pulse_err_clear();
    n_total++; if (rx_frame_err !== 1'b0) $display("FAIL ferr_clear: got %b want 0", rx_frame_err); else n_pass++;
  endtask

  task automatic test_glitch_and_stretch();
    got_q.delete(); got_cyc.delete();
    rx_ready = 1'b1;
    RXD = 1'b0;
    wait_clks(20);
    n_total++; if (rx_busy !== 1'b1) $display("FAIL glitch_busy: got %b want 1", rx_busy); else n_pass++;
    wait_clks(30);
    RXD = 1'b1;
    wait_clks(200);
    n_total++; if (rx_busy !== 1'b0) $display("FAIL glitch_idle: got %b want 0", rx_busy); else n_pass++;
    n_total++; if (got_q.size() !== 0) $display("FAIL glitch_no_byte: got %0d want 0", got_q.size()); else n_pass++;
    send_frame(8'h2A, 1'b1, 25);
    wait_clks(20);
    n_total++; if (got_q.size() !== 1) $display("FAIL stretch_count: got %0d want 1", got_q.size()); else n_pass++;
    if (got_q.size() >= 1) begin
      n_total++; if (got_q[0] !== 8'h2A) $display("FAIL stretch_data: got %h want 2a", got_q[0]); else n_pass++;
    end
    n_total++; if (rx_frame_err !== 1'b0) $display("FAIL stretch_frame_err: got %b want 0", rx_frame_err); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    got_q.delete(); got_cyc.delete();
    rx_ready = 1'b1;
    b = 8'h35;
    RXD = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 3; i++) begin
      RXD = b[i];
      wait_clks(CPB);
    end
    RXD = b[3];
    wait_clks(100);
    n_total++; if (rx_busy !== 1'b1) $display("FAIL rst_mid_busy_before: got %b want 1", rx_busy); else n_pass++;
    resetn = 1'b0;
    wait_clks(4);
    n_total++; if (rx_busy !== 1'b0) $display("FAIL rst_mid_busy_in_reset: got %b want 0", rx_busy); else n_pass++;
    resetn = 1'b1;
    wait_clks(2 * CPB);
    n_total++; if (rx_busy !== 1'b0) $display("FAIL rst_mid_no_start: got %b want 0", rx_busy); else n_pass++;
    n_total++; if (rx_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", rx_valid); else n_pass++;
    n_total++; if (rx_data !== 8'h00) $display("FAIL rst_mid_data: got %h want 00", rx_data); else n_pass++;
    n_total++; if (rx_frame_err !== 1'b0) $display("FAIL rst_mid_frame_err: got %b want 0", rx_frame_err); else n_pass++;
    RXD = 1'b1;
    wait_clks(20);
    send_frame(8'h39, 1'b1, 0);
    wait_clks(20);
    n_total++; if (got_q.size() !== 1) $display("FAIL rst_mid_next_count: got %0d want 1", got_q.size()); else n_pass++;
    if (got_q.size() >= 1) begin
      n_total++; if (got_q[0] !== 8'h39) $display("FAIL rst_mid_next_data: got %h want 39", got_q[0]); else n_pass++;
    end
    n_total++; if (rx_frame_err !== 1'b0) $display("FAIL rst_mid_next_frame_err: got %b want 0", rx_frame_err); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    resetn = 1'b0;
    RXD = 1'b1;
    rx_ready = 1'b0;
    err_clear = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overrun();
    test_frame_error();
    test_glitch_and_stretch();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
